// File: rtl/axil_pkg.sv
// axil_pkg: shared response codes and FSM state types for the AXI4-Lite slave front end
package axil_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    typedef enum logic [1:0] {WR_IDLE, WR_EXEC, WR_RESP} wr_state_t;
    typedef enum logic [1:0] {RD_IDLE, RD_EXEC, RD_RESP} rd_state_t;
endpackage

// File: rtl/axil_addr_decode.sv
// axil_addr_decode: byte address -> register index plus out-of-range flag
// Ports: addr (byte address in), idx (register index out), oor (address beyond the register file).
// Macro AXIL_ADDR_CHECK_EN enables the range check; without it upper bits are ignored and oor is 0.
module axil_addr_decode #(
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_REGS   = 16
) (
    input  logic [ADDR_WIDTH-1:0]       addr,
    output logic [$clog2(NUM_REGS)-1:0] idx,
    output logic                        oor
);
    localparam int IW = $clog2(NUM_REGS);
`ifdef AXIL_ADDR_CHECK_EN
    localparam bit CHECK = 1'b1;
`else
    localparam bit CHECK = 1'b0;
`endif
    assign idx = addr[2 +: IW];
    assign oor = CHECK && ((addr >> (2 + IW)) != '0);
endmodule

// File: rtl/axil_slave_ctrl.sv
// axil_slave_ctrl: AXI4-Lite slave front end producing single-cycle register-file strobes
// Ports: clk, rst (sync, active high); AXI-Lite slave channels s_aw*, s_w*, s_b*, s_ar*, s_r*;
// backend write strobe wr_en/wr_addr/wr_data/wr_strb; backend read rd_en/rd_addr with combinational rd_data.
// Macro AXIL_ADDR_CHECK_EN: out-of-range addresses answer SLVERR and never strobe the backend.
module axil_slave_ctrl
    import axil_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ADDR_WIDTH-1:0]       s_awaddr,
    input  logic                        s_awvalid,
    output logic                        s_awready,
    input  logic [DATA_WIDTH-1:0]       s_wdata,
    input  logic [DATA_WIDTH/8-1:0]     s_wstrb,
    input  logic                        s_wvalid,
    output logic                        s_wready,
    output logic [1:0]                  s_bresp,
    output logic                        s_bvalid,
    input  logic                        s_bready,
    input  logic [ADDR_WIDTH-1:0]       s_araddr,
    input  logic                        s_arvalid,
    output logic                        s_arready,
    output logic [DATA_WIDTH-1:0]       s_rdata,
    output logic [1:0]                  s_rresp,
    output logic                        s_rvalid,
    input  logic                        s_rready,
    output logic [$clog2(NUM_REGS)-1:0] wr_addr,
    output logic                        wr_en,
    output logic [DATA_WIDTH-1:0]       wr_data,
    output logic [DATA_WIDTH/8-1:0]     wr_strb,
    output logic [$clog2(NUM_REGS)-1:0] rd_addr,
    output logic                        rd_en,
    input  logic [DATA_WIDTH-1:0]       rd_data
);
    localparam int IW = $clog2(NUM_REGS);

    wr_state_t         wr_state, wr_next;
    rd_state_t         rd_state, rd_next;
    logic              aw_got, w_got, wr_err, rd_err;
    logic              aw_hs, w_hs, ar_hs;
    logic [IW-1:0]     aw_idx, ar_idx;
    logic              aw_oor, ar_oor;

    axil_addr_decode #(.ADDR_WIDTH(ADDR_WIDTH), .NUM_REGS(NUM_REGS)) u_wdec (
        .addr(s_awaddr), .idx(aw_idx), .oor(aw_oor)
    );
    axil_addr_decode #(.ADDR_WIDTH(ADDR_WIDTH), .NUM_REGS(NUM_REGS)) u_rdec (
        .addr(s_araddr), .idx(ar_idx), .oor(ar_oor)
    );

    // Readies are gated by rst so every ready reads 0 while reset is held.
    always_comb begin
        s_awready = !rst && wr_state == WR_IDLE && !aw_got;
        s_wready  = !rst && wr_state == WR_IDLE && !w_got;
        aw_hs     = s_awvalid && s_awready;
        w_hs      = s_wvalid && s_wready;
        wr_en     = wr_state == WR_EXEC && !wr_err;
        s_bvalid  = wr_state == WR_RESP;
        wr_next   = wr_state;
        if (wr_state == WR_IDLE && (aw_got || aw_hs) && (w_got || w_hs))
            wr_next = WR_EXEC;
        if (wr_state == WR_EXEC)
            wr_next = WR_RESP;
        if (wr_state == WR_RESP && s_bready)
            wr_next = WR_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state <= WR_IDLE;
            aw_got   <= 1'b0;
            w_got    <= 1'b0;
            wr_err   <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            wr_strb  <= '0;
            s_bresp  <= RESP_OKAY;
        end else begin
            wr_state <= wr_next;
            if (aw_hs) begin
                aw_got  <= 1'b1;
                wr_addr <= aw_idx;
                wr_err  <= aw_oor;
            end
            if (w_hs) begin
                w_got   <= 1'b1;
                wr_data <= s_wdata;
                wr_strb <= s_wstrb;
            end
            if (wr_state == WR_EXEC)
                s_bresp <= wr_err ? RESP_SLVERR : RESP_OKAY;
            if (wr_state == WR_RESP && s_bready) begin
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end
        end
    end

    always_comb begin
        s_arready = !rst && rd_state == RD_IDLE;
        ar_hs     = s_arvalid && s_arready;
        rd_en     = rd_state == RD_EXEC && !rd_err;
        s_rvalid  = rd_state == RD_RESP;
        rd_next   = rd_state;
        if (ar_hs)
            rd_next = RD_EXEC;
        if (rd_state == RD_EXEC)
            rd_next = RD_RESP;
        if (rd_state == RD_RESP && s_rready)
            rd_next = RD_IDLE;
    end

    // rd_data is sampled at the end of RD_EXEC, so a same-cycle backend write is not yet visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state <= RD_IDLE;
            rd_err   <= 1'b0;
            rd_addr  <= '0;
            s_rdata  <= '0;
            s_rresp  <= RESP_OKAY;
        end else begin
            rd_state <= rd_next;
            if (ar_hs) begin
                rd_addr <= ar_idx;
                rd_err  <= ar_oor;
            end
            if (rd_state == RD_EXEC) begin
                s_rdata <= rd_err ? '0 : rd_data;
                s_rresp <= rd_err ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end
endmodule

// File: tb/tb_axil_slave_ctrl.sv
// tb_axil_slave_ctrl: directed and randomized checks of axil_slave_ctrl against a transaction-level model
module tb_axil_slave_ctrl;
    localparam int NR = 16;
`ifdef AXIL_ADDR_CHECK_EN
    localparam bit CHECK = 1'b1;
`else
    localparam bit CHECK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] s_awaddr = '0, s_wdata = '0, s_araddr = '0;
    logic [3:0]  s_wstrb = '0;
    logic        s_awvalid = 0, s_wvalid = 0, s_bready = 0, s_arvalid = 0, s_rready = 0;
    logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid, wr_en, rd_en;
    logic [1:0]  s_bresp, s_rresp;
    logic [31:0] s_rdata, wr_data, rd_data;
    logic [3:0]  wr_strb, wr_addr, rd_addr;

    logic [31:0] mem [NR];
    logic [31:0] ref_mem [NR];
    int          wr_cnt = 0, rd_cnt = 0;
    int          n_chk = 0, n_fail = 0;

    axil_slave_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(NR)) dut (
        .clk(clk), .rst(rst),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .wr_addr(wr_addr), .wr_en(wr_en), .wr_data(wr_data), .wr_strb(wr_strb),
        .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Backend register file driven by the DUT strobes.
    assign rd_data = mem[rd_addr];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NR; i++) mem[i] <= 32'h1000_0000 + i;
        end else if (wr_en) begin
            mem[wr_addr] <= merge(mem[wr_addr], wr_data, wr_strb);
        end
        if (wr_en) wr_cnt <= wr_cnt + 1;
        if (rd_en) rd_cnt <= rd_cnt + 1;
    end

    task automatic init_ref();
        for (int i = 0; i < NR; i++) ref_mem[i] = 32'h1000_0000 + i;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // lead > 0: W precedes AW by lead cycles; lead < 0: AW precedes W.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int lead);
        int aw_at, w_at, c, cnt0;
        bit aw_ok, w_ok, af, wf, err;
        logic [1:0] er;
        logic [3:0] idx;
        err = CHECK && (a >= NR * 4);
        er = err ? 2'b10 : 2'b00;
        idx = a[5:2];
        aw_at = lead > 0 ? lead : 0;
        w_at = lead < 0 ? -lead : 0;
        cnt0 = wr_cnt;
        c = 0;
        aw_ok = 0;
        w_ok = 0;
        s_awaddr = a;
        s_wdata = d;
        s_wstrb = s;
        while (!(aw_ok && w_ok) && c < 20) begin
            if (c == aw_at) s_awvalid = 1;
            if (c == w_at) s_wvalid = 1;
            af = s_awvalid && s_awready;
            wf = s_wvalid && s_wready;
            aw_ok |= af;
            w_ok |= wf;
            step();
            c++;
            if (af) s_awvalid = 0;
            if (wf) s_wvalid = 0;
        end
        if (!(aw_ok && w_ok)) begin
            s_awvalid = 0;
            s_wvalid = 0;
            chk("wr_handshake_timeout", 32'd0, 32'd1);
            return;
        end
        chk("wr_en_n1", wr_en, !err);
        if (!err) begin
            chk("wr_addr", wr_addr, idx);
            chk("wr_data", wr_data, d);
            chk("wr_strb", wr_strb, s);
        end
        chk("bvalid_n1", s_bvalid, 0);
        step();
        chk("bvalid_n2", s_bvalid, 1);
        chk("bresp", s_bresp, er);
        chk("wr_en_n2", wr_en, 0);
        repeat ($urandom_range(2)) begin
            step();
            chk("bvalid_hold", s_bvalid, 1);
            chk("bresp_hold", s_bresp, er);
        end
        s_bready = 1;
        step();
        s_bready = 0;
        chk("bvalid_done", s_bvalid, 0);
        chk("wr_en_count", wr_cnt - cnt0, !err);
        if (!err) ref_mem[idx] = merge(ref_mem[idx], d, s);
    endtask

    task automatic do_read(input logic [31:0] a, input int rwait);
        int cnt0;
        bit err;
        logic [1:0] er;
        logic [3:0] idx;
        logic [31:0] exp;
        err = CHECK && (a >= NR * 4);
        er = err ? 2'b10 : 2'b00;
        idx = a[5:2];
        exp = err ? 32'd0 : ref_mem[idx];
        cnt0 = rd_cnt;
        s_araddr = a;
        s_arvalid = 1;
        chk("arready", s_arready, 1);
        step();
        s_arvalid = 0;
        chk("rd_en_n1", rd_en, !err);
        if (!err) chk("rd_addr", rd_addr, idx);
        chk("rvalid_n1", s_rvalid, 0);
        step();
        chk("rvalid_n2", s_rvalid, 1);
        chk("rdata", s_rdata, exp);
        chk("rresp", s_rresp, er);
        repeat (rwait) begin
            step();
            chk("rvalid_hold", s_rvalid, 1);
            chk("rdata_hold", s_rdata, exp);
            chk("rresp_hold", s_rresp, er);
        end
        s_rready = 1;
        step();
        s_rready = 0;
        chk("rvalid_done", s_rvalid, 0);
        chk("rd_en_count", rd_cnt - cnt0, !err);
    endtask

    initial begin
        logic [31:0] old_v, new_v;
        init_ref();
        step();
        step();
        chk("rst_awready", s_awready, 0);
        chk("rst_wready", s_wready, 0);
        chk("rst_arready", s_arready, 0);
        chk("rst_bvalid", s_bvalid, 0);
        chk("rst_rvalid", s_rvalid, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_bresp", s_bresp, 0);
        chk("rst_rresp", s_rresp, 0);
        chk("rst_rdata", s_rdata, 0);
        chk("rst_wr_addr", wr_addr, 0);
        rst = 0;
        step();
        chk("idle_awready", s_awready, 1);
        chk("idle_wready", s_wready, 1);
        chk("idle_arready", s_arready, 1);

        do_write(32'h08, 32'hDEADBEEF, 4'hF, 0);
        do_write(32'h04, 32'hA5A5_1234, 4'h3, 2);
        do_read(32'h08, 5);
        do_read(32'h04, 0);
        do_write(32'h40, 32'h0BAD_F00D, 4'hF, 0);
        do_read(32'h40, 1);
        do_write(32'h44, 32'h1357_9BDF, 4'hF, -1);
        do_read(32'h04, 0);

        // Concurrent write and read to index 3: the read sees the pre-write value.
        old_v = ref_mem[3];
        new_v = $urandom;
        s_awaddr = 32'h0C;
        s_wdata = new_v;
        s_wstrb = 4'hF;
        s_araddr = 32'h0C;
        s_awvalid = 1;
        s_wvalid = 1;
        s_arvalid = 1;
        step();
        s_awvalid = 0;
        s_wvalid = 0;
        s_arvalid = 0;
        chk("conc_wr_en", wr_en, 1);
        chk("conc_rd_en", rd_en, 1);
        step();
        chk("conc_bvalid", s_bvalid, 1);
        chk("conc_rvalid", s_rvalid, 1);
        chk("conc_rdata_old", s_rdata, old_v);
        s_bready = 1;
        s_rready = 1;
        step();
        s_bready = 0;
        s_rready = 0;
        chk("conc_bvalid_done", s_bvalid, 0);
        chk("conc_rvalid_done", s_rvalid, 0);
        ref_mem[3] = new_v;
        do_read(32'h0C, 0);

        // Reset while the write response is pending drops it.
        s_awaddr = 32'h10;
        s_wdata = 32'h5555_AAAA;
        s_wstrb = 4'hF;
        s_awvalid = 1;
        s_wvalid = 1;
        step();
        s_awvalid = 0;
        s_wvalid = 0;
        step();
        chk("pre_rst_bvalid", s_bvalid, 1);
        rst = 1;
        step();
        chk("mid_rst_bvalid", s_bvalid, 0);
        chk("mid_rst_awready", s_awready, 0);
        chk("mid_rst_wr_en", wr_en, 0);
        rst = 0;
        init_ref();
        step();
        chk("post_rst_awready", s_awready, 1);
        chk("post_rst_bvalid", s_bvalid, 0);

        for (int i = 0; i < 24; i++) begin
            logic [31:0] a;
            a = ($urandom_range(31) << 2) | $urandom_range(3);
            if ($urandom_range(1))
                do_write(a, $urandom, 4'($urandom_range(15)), int'($urandom_range(6)) - 3);
            else
                do_read(a, $urandom_range(3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
